xilinx_distram_fifo: RTL and testbench
======================================

XILINX_DISTRAM_FIFO -- requirements
Module: xilinx_distram_fifo

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 6, log2 of FIFO depth; DEPTH = 2**ADDR_WIDTH, legal 5..7.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 8, word width in bits, legal 1..64.
REQ-003 The block SHALL have parameter AFULL_THRESH, default DEPTH-4, occupancy at or above which ALMOST_FULL asserts, legal 1..DEPTH.
REQ-004 The block SHALL have port WCLK, input, 1, single clock; all state updates on the rising edge.
REQ-005 The block SHALL have port RST_N, input, 1; the reset is asynchronous and active-low.
REQ-006 The block SHALL have port WE, input, 1, write request.
REQ-007 The block SHALL have port D, input, DATA_WIDTH, write data.
REQ-008 The block SHALL have port RE, input, 1, read request.
REQ-009 The block SHALL have port DOUT, output, DATA_WIDTH, read data.
REQ-010 The block SHALL have port VALID, output, 1, DOUT holds a popped word.
REQ-011 The block SHALL have port EMPTY, output, 1, occupancy zero.
REQ-012 The block SHALL have port FULL, output, 1, occupancy equals DEPTH.
REQ-013 The block SHALL have port ALMOST_FULL, output, 1, occupancy >= AFULL_THRESH.
REQ-014 The block SHALL have port COUNT, output, ADDR_WIDTH+1, current occupancy.
REQ-015 The block SHALL have port OVERFLOW, output, 1, one-cycle pulse on a rejected write.
REQ-016 The block SHALL have port UNDERFLOW, output, 1, one-cycle pulse on a rejected read.

Function
REQ-017 Storage SHALL be DATA_WIDTH dual-port distributed LUT RAM columns of DEPTH x 1; write port addressed by the write pointer, read port (DPRA) by the read pointer.
REQ-018 Write pointer and read pointer SHALL be ADDR_WIDTH bits and wrap from DEPTH-1 to 0; COUNT is ADDR_WIDTH+1 bits, so the full DEPTH words are usable.
REQ-019 An accepted write (WE=1 and FULL=0, or WE=1 and FULL=1 and RE=1) SHALL store D at the write pointer and increment it at the same edge.
REQ-020 A write with WE=1, FULL=1, RE=0 SHALL be discarded, leave all state unchanged, and pulse OVERFLOW high for the following cycle.
REQ-021 An accepted read (RE=1 and EMPTY=0) SHALL increment the read pointer; RE=1 with EMPTY=1 SHALL be discarded and pulse UNDERFLOW for the following cycle, even if WE=1 in the same cycle.
REQ-022 COUNT SHALL increment on write-only, decrement on read-only, and hold when both are accepted together.
REQ-023 EMPTY, FULL, ALMOST_FULL SHALL be registered and SHALL reflect the post-edge COUNT in the same cycle COUNT updates (zero-cycle lag from COUNT).
REQ-024 A word written at edge N SHALL be readable (EMPTY=0) from edge N onward; write-to-read latency is one cycle.
REQ-025 With FULL=1, simultaneous WE and RE SHALL be both accepted: the oldest word is read, the new word is written to the freed slot, FULL stays 1.

Reset
REQ-026 RST_N low SHALL asynchronously clear both pointers and COUNT to 0, set EMPTY=1, FULL=0, ALMOST_FULL=0, VALID=0, OVERFLOW=0, UNDERFLOW=0, DOUT=0.
REQ-027 RAM contents SHALL not be reset (INIT all-zero at configuration); after reset mid-operation, prior contents are unreachable because the FIFO is empty.
REQ-028 Deassertion of RST_N SHALL be treated as synchronous to WCLK by the integrator; the first request is honoured on the first rising edge with RST_N high.

Configuration
REQ-029 Macro XILINX_DISTRAM_FIFO_FWFT_EN SHALL select first-word-fall-through read mode.
REQ-030 Without the macro: DOUT SHALL be a register loaded from the RAM read port on an accepted read, VALID high for exactly the cycle after each accepted read, DOUT holding its value otherwise.
REQ-031 With the macro: DOUT SHALL be driven combinationally from the RAM read port at the read pointer, VALID SHALL equal not EMPTY, and RE acts as acknowledge of the displayed word.

Verification
REQ-032 Reset, then write 0x11,0x22,0x33 on three cycles -> COUNT=3, EMPTY=0 after first write edge; three reads return 0x11,0x22,0x33 in order (standard: one cycle after each RE; FWFT: 0x11 on DOUT the cycle after first write).
REQ-033 ADDR_WIDTH=5: write 32 words -> FULL=1, COUNT=32, ALMOST_FULL asserted at COUNT=28; 33rd write -> OVERFLOW pulses 1 cycle, COUNT stays 32, contents unchanged.
REQ-034 FIFO full, WE=1 RE=1 with D=0xAA -> oldest word read, COUNT stays 32, FULL stays 1; draining returns 0xAA last.
REQ-035 FIFO empty, WE=1 RE=1 with D=0x5A -> UNDERFLOW pulses, COUNT=1, next read returns 0x5A.
REQ-036 Write 40 and read 40 words interleaved at ADDR_WIDTH=5 -> pointers wrap, data order preserved; RST_N pulsed low mid-stream with COUNT=7 -> EMPTY=1, COUNT=0, DOUT=0 immediately, no old word returned afterwards.

Source files
------------

// File: rtl/xilinx_distram_fifo.sv
// Single-clock FIFO built on dual-port distributed LUT RAM, with optional first-word-fall-through output.
// Latency: a write is visible (EMPTY=0) right after its edge; standard mode presents read data one cycle after RE.
// Backpressure: FULL/ALMOST_FULL for the writer and EMPTY for the reader; rejected requests pulse OVERFLOW/UNDERFLOW.
//
// Optional feature macro: XILINX_DISTRAM_FIFO_FWFT_EN
//   undefined : DOUT is a register loaded on each accepted read; VALID pulses for the cycle after that read.
//   defined   : DOUT shows the word at the read pointer combinationally; VALID = !EMPTY and RE acknowledges it.
//
// Parameters
//   ADDR_WIDTH   : log2 of depth (5..7), DEPTH = 2**ADDR_WIDTH
//   DATA_WIDTH   : word width (1..64)
//   AFULL_THRESH : occupancy at or above which ALMOST_FULL is set (1..DEPTH)
//
// Ports
//   WCLK        in   clock; every state update happens on its rising edge
//   RST_N       in   asynchronous active-low reset (release synchronised externally)
//   WE, D       in   write request and write data
//   RE          in   read request (acknowledge in FWFT mode)
//   DOUT        out  read data
//   VALID       out  DOUT holds a popped word
//   EMPTY       out  occupancy is zero
//   FULL        out  occupancy equals DEPTH
//   ALMOST_FULL out  occupancy >= AFULL_THRESH
//   COUNT       out  occupancy, ADDR_WIDTH+1 bits so all DEPTH slots are usable
//   OVERFLOW    out  one-cycle pulse after a rejected write
//   UNDERFLOW   out  one-cycle pulse after a rejected read

module xilinx_distram_fifo #(
    parameter int ADDR_WIDTH   = 6,
    parameter int DATA_WIDTH   = 8,
    parameter int AFULL_THRESH = (2 ** ADDR_WIDTH) - 4
) (
    input  logic                  WCLK,
    input  logic                  RST_N,
    input  logic                  WE,
    input  logic [DATA_WIDTH-1:0] D,
    input  logic                  RE,
    output logic [DATA_WIDTH-1:0] DOUT,
    output logic                  VALID,
    output logic                  EMPTY,
    output logic                  FULL,
    output logic                  ALMOST_FULL,
    output logic [ADDR_WIDTH:0]   COUNT,
    output logic                  OVERFLOW,
    output logic                  UNDERFLOW
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    // Occupancy constants at COUNT width.
    localparam logic [ADDR_WIDTH:0] C_DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] C_AFULL = AFULL_THRESH[ADDR_WIDTH:0];

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_count;
    logic                  r_empty;
    logic                  r_full;
    logic                  r_afull;
    logic                  r_ovf;
    logic                  r_unf;

    logic                  w_wr_acc;
    logic                  w_rd_acc;
    logic                  w_ovf;
    logic                  w_unf;
    logic [ADDR_WIDTH:0]   w_count_nxt;
    logic [DATA_WIDTH-1:0] w_rd_word;

    // ------------------------------------------------------------------
    // Request qualification
    // ------------------------------------------------------------------
    // A write while full is still taken when a read frees the oldest slot in
    // the same cycle. A read while empty is always refused, even when a write
    // lands in the same cycle: the new word is not yet the read-port output.
    always_comb begin
        w_rd_acc    = RE & ~r_empty;
        w_wr_acc    = WE & (~r_full | RE);
        w_ovf       = WE & r_full & ~RE;
        w_unf       = RE & r_empty;
        w_count_nxt = r_count;
        case ({w_wr_acc, w_rd_acc})
            2'b10:   w_count_nxt = r_count + {{ADDR_WIDTH{1'b0}}, 1'b1};
            2'b01:   w_count_nxt = r_count - {{ADDR_WIDTH{1'b0}}, 1'b1};
            default: w_count_nxt = r_count;
        endcase
    end

    // ------------------------------------------------------------------
    // Pointers, occupancy and status flags
    // ------------------------------------------------------------------
    // Flags are decoded from the next occupancy so that they change on the
    // same edge as COUNT instead of trailing it by a cycle.
    always_ff @(posedge WCLK or negedge RST_N) begin
        if (!RST_N) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_empty  <= 1'b1;
            r_full   <= 1'b0;
            r_afull  <= 1'b0;
            r_ovf    <= 1'b0;
            r_unf    <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= w_count_nxt;
            r_empty <= (w_count_nxt == '0);
            r_full  <= (w_count_nxt == C_DEPTH);
            r_afull <= (w_count_nxt >= C_AFULL);
            r_ovf   <= w_ovf;
            r_unf   <= w_unf;
        end
    end

    // ------------------------------------------------------------------
    // Storage: one DEPTH x 1 dual-port LUT RAM column per data bit
    // ------------------------------------------------------------------
    // No reset on the columns so they map onto distributed RAM primitives;
    // they power up zero from the configuration image. After a reset the
    // stale contents are never read because the FIFO restarts empty.
    for (genvar b = 0; b < DATA_WIDTH; b++) begin : g_col
        logic [DEPTH-1:0] r_col;

        always_ff @(posedge WCLK) begin
            if (w_wr_acc) begin
                r_col[r_wr_ptr] <= D[b];
            end
        end

        // Asynchronous read port (DPRA) addressed by the read pointer.
        assign w_rd_word[b] = r_col[r_rd_ptr];
    end

    // ------------------------------------------------------------------
    // Read data presentation
    // ------------------------------------------------------------------
`ifdef XILINX_DISTRAM_FIFO_FWFT_EN
    // The head word is on DOUT as soon as it is written; forcing zero while
    // empty keeps DOUT at 0 out of reset instead of showing stale RAM.
    assign DOUT  = r_empty ? '0 : w_rd_word;
    assign VALID = ~r_empty;
`else
    logic [DATA_WIDTH-1:0] r_dout;
    logic                  r_valid;

    always_ff @(posedge WCLK or negedge RST_N) begin
        if (!RST_N) begin
            r_dout  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= w_rd_acc;
            if (w_rd_acc) begin
                r_dout <= w_rd_word;
            end
        end
    end

    assign DOUT  = r_dout;
    assign VALID = r_valid;
`endif

    assign EMPTY       = r_empty;
    assign FULL        = r_full;
    assign ALMOST_FULL = r_afull;
    assign COUNT       = r_count;
    assign OVERFLOW    = r_ovf;
    assign UNDERFLOW   = r_unf;

endmodule

// File: tb/tb_xilinx_distram_fifo.sv
// Self-checking bench for xilinx_distram_fifo (standard read mode, ADDR_WIDTH=5).
// Reference model: a queue of words plus the expected registered read output.
// Each scenario task drives stimulus and compares DUT outputs against the model inline.

module tb_xilinx_distram_fifo;

    localparam int AW    = 5;
    localparam int DW    = 8;
    localparam int DEPTH = 32;
    localparam int AFT   = 28;

    logic          WCLK = 1'b0;
    logic          RST_N = 1'b0;
    logic          WE = 1'b0;
    logic [DW-1:0] D = '0;
    logic          RE = 1'b0;
    logic [DW-1:0] DOUT;
    logic          VALID;
    logic          EMPTY;
    logic          FULL;
    logic          ALMOST_FULL;
    logic [AW:0]   COUNT;
    logic          OVERFLOW;
    logic          UNDERFLOW;

    xilinx_distram_fifo #(
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .AFULL_THRESH(AFT)
    ) dut (
        .WCLK       (WCLK),
        .RST_N      (RST_N),
        .WE         (WE),
        .D          (D),
        .RE         (RE),
        .DOUT       (DOUT),
        .VALID      (VALID),
        .EMPTY      (EMPTY),
        .FULL       (FULL),
        .ALMOST_FULL(ALMOST_FULL),
        .COUNT      (COUNT),
        .OVERFLOW   (OVERFLOW),
        .UNDERFLOW  (UNDERFLOW)
    );

    always #5 WCLK = ~WCLK;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    logic [DW-1:0] q[$];
    logic [DW-1:0] m_dout  = '0;
    logic          m_valid = 1'b0;
    logic          m_ovf   = 1'b0;
    logic          m_unf   = 1'b0;

    task automatic model_reset();
        q.delete();
        m_dout  = '0;
        m_valid = 1'b0;
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
    endtask

    // One clock of stimulus; the model follows the FIFO rules on the queue.
    task automatic step(input logic we, input logic [DW-1:0] d, input logic re);
        bit full, empty, wr, rd;
        full  = (q.size() == DEPTH);
        empty = (q.size() == 0);
        wr    = we && (!full || re);
        rd    = re && !empty;
        WE = we;
        D  = d;
        RE = re;
        @(posedge WCLK);
        m_ovf = we && full && !re;
        m_unf = re && empty;
        if (rd) begin
            m_dout  = q.pop_front();
            m_valid = 1'b1;
        end else begin
            m_valid = 1'b0;
        end
        if (wr) q.push_back(d);
        #1;
        WE = 1'b0;
        RE = 1'b0;
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        #12;
        n_vec++; if (COUNT !== '0) begin n_err++; $display("FAIL rst_count got %0d want 0", COUNT); end
        n_vec++; if (EMPTY !== 1'b1) begin n_err++; $display("FAIL rst_empty got %b want 1", EMPTY); end
        n_vec++; if (FULL !== 1'b0) begin n_err++; $display("FAIL rst_full got %b want 0", FULL); end
        n_vec++; if (ALMOST_FULL !== 1'b0) begin n_err++; $display("FAIL rst_afull got %b want 0", ALMOST_FULL); end
        n_vec++; if (VALID !== 1'b0) begin n_err++; $display("FAIL rst_valid got %b want 0", VALID); end
        n_vec++; if (OVERFLOW !== 1'b0 || UNDERFLOW !== 1'b0) begin n_err++; $display("FAIL rst_pulses got ovf=%b unf=%b want 0 0", OVERFLOW, UNDERFLOW); end
        n_vec++; if (DOUT !== '0) begin n_err++; $display("FAIL rst_dout got %h want 00", DOUT); end
        @(negedge WCLK);
        RST_N = 1'b1;
        model_reset();
    endtask

    task automatic test_basic();
        logic [DW-1:0] exp_w [3];
        exp_w[0] = 8'h11; exp_w[1] = 8'h22; exp_w[2] = 8'h33;
        step(1'b1, exp_w[0], 1'b0);
        n_vec++; if (EMPTY !== 1'b0) begin n_err++; $display("FAIL basic_empty_after_first got %b want 0", EMPTY); end
        n_vec++; if (COUNT !== 6'd1) begin n_err++; $display("FAIL basic_count1 got %0d want 1", COUNT); end
        step(1'b1, exp_w[1], 1'b0);
        step(1'b1, exp_w[2], 1'b0);
        n_vec++; if (COUNT !== 6'd3) begin n_err++; $display("FAIL basic_count3 got %0d want 3", COUNT); end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, '0, 1'b1);
            n_vec++; if (VALID !== 1'b1 || DOUT !== exp_w[i]) begin
                n_err++; $display("FAIL basic_read%0d got valid=%b dout=%h want 1 %h", i, VALID, DOUT, exp_w[i]);
            end
        end
        step(1'b0, '0, 1'b0);
        n_vec++; if (VALID !== 1'b0 || DOUT !== 8'h33 || EMPTY !== 1'b1) begin
            n_err++; $display("FAIL basic_idle got valid=%b dout=%h empty=%b want 0 33 1", VALID, DOUT, EMPTY);
        end
    endtask

    task automatic test_fill_overflow();
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, DW'($urandom), 1'b0);
            n_vec++; if (COUNT !== 6'(q.size()) || ALMOST_FULL !== (q.size() >= AFT) || FULL !== (q.size() == DEPTH)) begin
                n_err++; $display("FAIL fill_%0d got count=%0d af=%b full=%b want %0d %b %b", i, COUNT, ALMOST_FULL, FULL,
                                  q.size(), (q.size() >= AFT), (q.size() == DEPTH));
            end
        end
        step(1'b1, 8'hEE, 1'b0);
        n_vec++; if (OVERFLOW !== 1'b1 || COUNT !== 6'd32 || FULL !== 1'b1) begin
            n_err++; $display("FAIL overflow got ovf=%b count=%0d full=%b want 1 32 1", OVERFLOW, COUNT, FULL);
        end
        step(1'b0, '0, 1'b0);
        n_vec++; if (OVERFLOW !== 1'b0) begin n_err++; $display("FAIL overflow_one_cycle got %b want 0", OVERFLOW); end
    endtask

    task automatic test_full_rw();
        step(1'b1, 8'hAA, 1'b1);
        n_vec++; if (VALID !== 1'b1 || DOUT !== m_dout) begin
            n_err++; $display("FAIL fullrw_oldest got valid=%b dout=%h want 1 %h", VALID, DOUT, m_dout);
        end
        n_vec++; if (COUNT !== 6'd32 || FULL !== 1'b1 || OVERFLOW !== 1'b0) begin
            n_err++; $display("FAIL fullrw_state got count=%0d full=%b ovf=%b want 32 1 0", COUNT, FULL, OVERFLOW);
        end
        while (q.size() > 0) begin
            step(1'b0, '0, 1'b1);
            n_vec++; if (VALID !== 1'b1 || DOUT !== m_dout || COUNT !== 6'(q.size())) begin
                n_err++; $display("FAIL fullrw_drain got valid=%b dout=%h count=%0d want 1 %h %0d", VALID, DOUT, COUNT, m_dout, q.size());
            end
        end
        n_vec++; if (DOUT !== 8'hAA) begin n_err++; $display("FAIL fullrw_last got %h want aa", DOUT); end
        step(1'b0, '0, 1'b1);
        n_vec++; if (UNDERFLOW !== 1'b1 || VALID !== 1'b0 || EMPTY !== 1'b1) begin
            n_err++; $display("FAIL underflow got unf=%b valid=%b empty=%b want 1 0 1", UNDERFLOW, VALID, EMPTY);
        end
    endtask

    task automatic test_empty_rw();
        step(1'b1, 8'h5A, 1'b1);
        n_vec++; if (UNDERFLOW !== 1'b1 || COUNT !== 6'd1 || VALID !== 1'b0 || EMPTY !== 1'b0) begin
            n_err++; $display("FAIL emptyrw got unf=%b count=%0d valid=%b empty=%b want 1 1 0 0", UNDERFLOW, COUNT, VALID, EMPTY);
        end
        step(1'b0, '0, 1'b1);
        n_vec++; if (DOUT !== 8'h5A || VALID !== 1'b1 || UNDERFLOW !== 1'b0 || COUNT !== 6'd0) begin
            n_err++; $display("FAIL emptyrw_read got dout=%h valid=%b unf=%b count=%0d want 5a 1 0 0", DOUT, VALID, UNDERFLOW, COUNT);
        end
    endtask

    task automatic test_wrap();
        int nw, nr, iter;
        logic we, re;
        nw = 0; nr = 0; iter = 0;
        while ((nw < 40 || nr < 40) && iter < 600) begin
            we = (nw < 40) && ($urandom_range(0, 1) == 1);
            re = ($urandom_range(0, 1) == 1);
            if (we && (q.size() < DEPTH || re)) nw++;
            if (re && q.size() > 0) nr++;
            step(we, DW'($urandom), re);
            iter++;
            n_vec++; if (DOUT !== m_dout || VALID !== m_valid || COUNT !== 6'(q.size()) || UNDERFLOW !== m_unf) begin
                n_err++; $display("FAIL wrap_%0d got dout=%h valid=%b count=%0d unf=%b want %h %b %0d %b",
                                  iter, DOUT, VALID, COUNT, UNDERFLOW, m_dout, m_valid, q.size(), m_unf);
            end
        end
        n_vec++; if (nw < 40 || nr < 40) begin n_err++; $display("FAIL wrap_budget got %0d/%0d want 40/40", nw, nr); end
    endtask

    task automatic test_random();
        logic we, re;
        for (int i = 0; i < 500; i++) begin
            we = ($urandom_range(0, 99) < ((i < 250) ? 65 : 35));
            re = ($urandom_range(0, 99) < ((i < 250) ? 40 : 65));
            step(we, DW'($urandom), re);
            n_vec++; if (DOUT !== m_dout || VALID !== m_valid || COUNT !== 6'(q.size()) || EMPTY !== (q.size() == 0) ||
                         FULL !== (q.size() == DEPTH) || ALMOST_FULL !== (q.size() >= AFT) ||
                         OVERFLOW !== m_ovf || UNDERFLOW !== m_unf) begin
                n_err++; $display("FAIL random_%0d got dout=%h v=%b cnt=%0d e=%b f=%b af=%b o=%b u=%b want %h %b %0d %b %b %b %b %b",
                                  i, DOUT, VALID, COUNT, EMPTY, FULL, ALMOST_FULL, OVERFLOW, UNDERFLOW,
                                  m_dout, m_valid, q.size(), (q.size() == 0), (q.size() == DEPTH), (q.size() >= AFT), m_ovf, m_unf);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] nw_w [3];
        nw_w[0] = 8'hC1; nw_w[1] = 8'hC2; nw_w[2] = 8'hC3;
        while (q.size() > 0) step(1'b0, '0, 1'b1);
        for (int i = 0; i < 7; i++) step(1'b1, DW'($urandom), 1'b0);
        step(1'b0, '0, 1'b1);
        step(1'b1, 8'h77, 1'b0);
        n_vec++; if (COUNT !== 6'd7) begin n_err++; $display("FAIL midrst_pre got %0d want 7", COUNT); end
        #2;
        RST_N = 1'b0;
        #1;
        n_vec++; if (EMPTY !== 1'b1 || COUNT !== '0 || DOUT !== '0 || VALID !== 1'b0 || FULL !== 1'b0) begin
            n_err++; $display("FAIL midrst got empty=%b count=%0d dout=%h valid=%b full=%b want 1 0 00 0 0", EMPTY, COUNT, DOUT, VALID, FULL);
        end
        model_reset();
        @(negedge WCLK);
        RST_N = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b1, nw_w[i], 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, '0, 1'b1);
            n_vec++; if (VALID !== 1'b1 || DOUT !== nw_w[i]) begin
                n_err++; $display("FAIL midrst_read%0d got valid=%b dout=%h want 1 %h", i, VALID, DOUT, nw_w[i]);
            end
        end
        step(1'b0, '0, 1'b1);
        n_vec++; if (UNDERFLOW !== 1'b1 || VALID !== 1'b0 || DOUT !== 8'hC3) begin
            n_err++; $display("FAIL midrst_noold got unf=%b valid=%b dout=%h want 1 0 c3", UNDERFLOW, VALID, DOUT);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_fill_overflow();
        test_full_rw();
        test_empty_rw();
        test_wrap();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
